// File: rtl/pc_flow_unit_pkg.sv
// Shared program-flow definitions: condition codes, status flag bit positions
// and default widths, also consumed by the controller and the ALU.
package pc_flow_unit_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 16;
  localparam int NUM_FLAGS   = 5;

  // Status register layout {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [3:0] COND_EQ     = 4'h0;
  localparam logic [3:0] COND_NE     = 4'h1;
  localparam logic [3:0] COND_CS     = 4'h2;
  localparam logic [3:0] COND_CC     = 4'h3;
  localparam logic [3:0] COND_HI     = 4'h4;
  localparam logic [3:0] COND_LS     = 4'h5;
  localparam logic [3:0] COND_GT     = 4'h6;
  localparam logic [3:0] COND_LE     = 4'h7;
  localparam logic [3:0] COND_FS     = 4'h8;
  localparam logic [3:0] COND_FC     = 4'h9;
  localparam logic [3:0] COND_LO     = 4'hA;
  localparam logic [3:0] COND_HS     = 4'hB;
  localparam logic [3:0] COND_LT     = 4'hC;
  localparam logic [3:0] COND_GE     = 4'hD;
  localparam logic [3:0] COND_UC     = 4'hE;
  localparam logic [3:0] COND_ALWAYS = 4'hF;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_JUMP,
    PC_BRANCH
  } pc_sel_e;

endpackage

// File: rtl/pc_flow_unit_cond_eval.sv
// Combinational condition-code evaluator: maps a 4-bit flag op and the
// status flags to a single take/don't-take bit.
module cond_eval
  import pc_flow_unit_pkg::*;
(
  input  logic [3:0]           flag_op,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic                 cond
);

  logic c_flag, l_flag, f_flag, z_flag, n_flag;

  assign c_flag = flags[FLAG_C];
  assign l_flag = flags[FLAG_L];
  assign f_flag = flags[FLAG_F];
  assign z_flag = flags[FLAG_Z];
  assign n_flag = flags[FLAG_N];

  always_comb begin
    cond = 1'b0;
    case (flag_op)
      COND_EQ:     cond = z_flag;
      COND_NE:     cond = !z_flag;
      COND_CS:     cond = c_flag;
      COND_CC:     cond = !c_flag;
      COND_HI:     cond = l_flag;
      COND_LS:     cond = !l_flag;
      COND_GT:     cond = n_flag;
      COND_LE:     cond = !n_flag;
      COND_FS:     cond = f_flag;
      COND_FC:     cond = !f_flag;
      COND_LO:     cond = !l_flag && !z_flag;
      COND_HS:     cond = l_flag || z_flag;
      COND_LT:     cond = !n_flag && !z_flag;
      COND_GE:     cond = n_flag || z_flag;
      COND_UC:     cond = 1'b1;
      COND_ALWAYS: cond = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_flow_unit.sv
// Program-flow responder: owns PC, status flags and instruction register,
// resolves jump/branch/increment commands and drives the fetch address.
module pc_flow_unit
  import pc_flow_unit_pkg::*;
#(
  parameter int               WIDTH    = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetchPhase,
  input  logic                   pcAdd,
  input  logic                   pcJump,
  input  logic                   pcBranch,
  input  logic [3:0]             flagOp,
  input  logic [WIDTH-1:0]       immediate,
  input  logic [WIDTH-1:0]       jump_target,
  input  logic                   flagWrite,
  input  logic [NUM_FLAGS-1:0]   alu_flags,
  input  logic [WIDTH-1:0]       mem_rdata,
  output logic [WIDTH-1:0]       mem_addr,
  output logic [WIDTH-1:0]       pc,
  output logic [WIDTH-1:0]       link,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [NUM_FLAGS-1:0]   flags,
  output logic                   taken
);

  logic [WIDTH-1:0]       pc_reg;
  logic [WIDTH-1:0]       pc_next;
  logic [WIDTH-1:0]       pc_plus_one;
  logic [NUM_FLAGS-1:0]   flags_reg;
  logic [INSTR_WIDTH-1:0] ir_reg;
  logic [INSTR_WIDTH-1:0] rdata_word;
  logic                   taken_reg;
  logic                   taken_next;
  logic                   cond;
  pc_sel_e                pc_sel;

  // Conditions always see the registered flags, never a same-cycle flagWrite.
  cond_eval u_cond_eval (
    .flag_op (flagOp),
    .flags   (flags_reg),
    .cond    (cond)
  );

  assign pc_plus_one = pc_reg + WIDTH'(1);

  generate
    if (WIDTH >= INSTR_WIDTH) begin : g_rdata_trunc
      assign rdata_word = mem_rdata[INSTR_WIDTH-1:0];
    end else begin : g_rdata_ext
      assign rdata_word = {{(INSTR_WIDTH-WIDTH){1'b0}}, mem_rdata};
    end
  endgenerate

  always_comb begin
    pc_sel = PC_HOLD;
    if (pcJump)        pc_sel = cond ? PC_JUMP : PC_INC;
    else if (pcBranch) pc_sel = cond ? PC_BRANCH : PC_INC;
    else if (pcAdd)    pc_sel = PC_INC;
  end

  always_comb begin
    pc_next    = pc_reg;
    taken_next = 1'b0;
    case (pc_sel)
      PC_INC:    pc_next = pc_plus_one;
      PC_JUMP: begin
        pc_next    = jump_target;
        taken_next = 1'b1;
      end
      PC_BRANCH: begin
        pc_next    = pc_reg + immediate;
        taken_next = 1'b1;
      end
      default:   pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_PC;
      flags_reg <= '0;
      ir_reg    <= '0;
      taken_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      taken_reg <= taken_next;
      if (flagWrite)  flags_reg <= alu_flags;
      if (fetchPhase) ir_reg    <= rdata_word;
    end
  end

  assign pc          = pc_reg;
  assign mem_addr    = pc_reg;
  assign link        = pc_plus_one;
  assign instruction = fetchPhase ? rdata_word : ir_reg;
  assign flags       = flags_reg;
  assign taken       = taken_reg;

endmodule

// File: tb/tb_pc_flow_unit.sv
// Self-checking bench for pc_flow_unit: directed scenarios followed by random
// command streams, all compared against a behavioural model.
module tb_pc_flow_unit;

  logic        clk;
  logic        reset;
  logic        fetchPhase;
  logic        pcAdd;
  logic        pcJump;
  logic        pcBranch;
  logic [3:0]  flagOp;
  logic [15:0] immediate;
  logic [15:0] jump_target;
  logic        flagWrite;
  logic [4:0]  alu_flags;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic [15:0] pc;
  logic [15:0] link;
  logic [15:0] instruction;
  logic [4:0]  flags;
  logic        taken;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Behavioural model state
  int          m_pc;
  logic [4:0]  m_flags;
  logic [15:0] m_ir;
  logic        m_taken;

  pc_flow_unit dut (
    .clk         (clk),
    .reset       (reset),
    .fetchPhase  (fetchPhase),
    .pcAdd       (pcAdd),
    .pcJump      (pcJump),
    .pcBranch    (pcBranch),
    .flagOp      (flagOp),
    .immediate   (immediate),
    .jump_target (jump_target),
    .flagWrite   (flagWrite),
    .alu_flags   (alu_flags),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .pc          (pc),
    .link        (link),
    .instruction (instruction),
    .flags       (flags),
    .taken       (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Condition table: C=bit4 L=bit3 F=bit2 Z=bit1 N=bit0
  function automatic bit ref_cond(input int op, input logic [4:0] f);
    bit c, l, ff, z, n;
    c = f[4]; l = f[3]; ff = f[2]; z = f[1]; n = f[0];
    case (op)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return l;
      5:  return !l;
      6:  return n;
      7:  return !n;
      8:  return ff;
      9:  return !ff;
      10: return !l && !z;
      11: return l || z;
      12: return !n && !z;
      13: return n || z;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_flags = '0; m_ir = '0; m_taken = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_pc"},    32'(pc),    32'h0);
    check_value({tag, "_taken"}, 32'(taken), 32'h0);
    check_value({tag, "_flags"}, 32'(flags), 32'h0);
    check_value({tag, "_ir"},    32'(instruction), 32'h0);
  endtask

  // One controller cycle: drive, check combinational outputs, clock, check state.
  task automatic do_cycle(input bit fetch, input bit add, input bit jmp, input bit br,
                          input logic [3:0] op, input logic [15:0] imm,
                          input logic [15:0] tgt, input bit fw,
                          input logic [4:0] af, input logic [15:0] rdata);
    bit c;
    fetchPhase = fetch; pcAdd = add; pcJump = jmp; pcBranch = br;
    flagOp = op; immediate = imm; jump_target = tgt; flagWrite = fw;
    alu_flags = af; mem_rdata = rdata;
    #1;
    check_value("mem_addr", 32'(mem_addr), 32'(m_pc));
    check_value("link", 32'(link), 32'((m_pc + 1) % 65536));
    check_value("instr", 32'(instruction), 32'(fetch ? rdata : m_ir));
    @(posedge clk);
    c = ref_cond(int'(op), m_flags);
    if (jmp) begin
      m_pc = c ? int'(tgt) : (m_pc + 1) % 65536;
      m_taken = c;
    end else if (br) begin
      m_pc = c ? (m_pc + int'(imm)) % 65536 : (m_pc + 1) % 65536;
      m_taken = c;
    end else begin
      if (add) m_pc = (m_pc + 1) % 65536;
      m_taken = 1'b0;
    end
    if (fw) m_flags = af;
    if (fetch) m_ir = rdata;
    #1;
    check_value("pc", 32'(pc), 32'(m_pc));
    check_value("flags", 32'(flags), 32'(m_flags));
    check_value("taken", 32'(taken), 32'(m_taken));
    n_txn++;
    $display("txn %0d: f=%0b a=%0b j=%0b b=%0b op=%h imm=%h tgt=%h fw=%0b -> pc=%h flags=%b taken=%0b",
             n_txn, fetch, add, jmp, br, op, imm, tgt, fw, pc, flags, taken);
  endtask

  task automatic idle_cycle();
    do_cycle(0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 5'h0, 16'h0);
  endtask

  task automatic jump_to(input logic [15:0] tgt);
    do_cycle(0, 0, 1, 0, 4'hF, 16'h0, tgt, 0, 5'h0, 16'h0);
  endtask

  initial begin
    reset = 1'b0;
    fetchPhase = 0; pcAdd = 0; pcJump = 0; pcBranch = 0; flagOp = '0;
    immediate = '0; jump_target = '0; flagWrite = 0; alu_flags = '0; mem_rdata = '0;
    model_reset();
    #3;
    check_reset_state("por");
    #9;
    reset = 1'b1;

    // Fetch: zero-latency instruction, then held by ir
    do_cycle(1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 5'h0, 16'h5103);
    check_value("fetch_pc", 32'(pc), 32'h0);
    do_cycle(0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 0, 5'h0, 16'hDEAD);
    check_value("ir_hold", 32'(instruction), 32'h5103);

    // Three increments
    repeat (3) do_cycle(0, 1, 0, 0, 4'h0, 16'h0, 16'h0, 0, 5'h0, 16'h0);
    check_value("add3_pc", 32'(pc), 32'h3);
    check_value("add3_link", 32'(link), 32'h4);

    // Wrap
    do_cycle(0, 0, 1, 0, 4'hE, 16'h0, 16'hFFFF, 0, 5'h0, 16'h0);
    do_cycle(0, 1, 0, 0, 4'h0, 16'h0, 16'h0, 0, 5'h0, 16'h0);
    check_value("wrap_pc", 32'(pc), 32'h0);

    // Branch EQ taken / NE not taken with Z set
    do_cycle(0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 1, 5'b00010, 16'h0);
    jump_to(16'd10);
    do_cycle(0, 0, 0, 1, 4'h0, 16'hFFFC, 16'h0, 0, 5'h0, 16'h0);
    check_value("beq_pc", 32'(pc), 32'd6);
    check_value("beq_taken", 32'(taken), 32'h1);
    jump_to(16'd10);
    do_cycle(0, 0, 0, 1, 4'h1, 16'hFFFC, 16'h0, 0, 5'h0, 16'h0);
    check_value("bne_pc", 32'(pc), 32'd11);
    check_value("bne_taken", 32'(taken), 32'h0);

    // JAL: pcAdd reaching 0x40 exposes link 0x41, then jump
    jump_to(16'h003F);
    do_cycle(0, 1, 0, 0, 4'h0, 16'h0, 16'h0, 0, 5'h0, 16'h0);
    check_value("jal_link", 32'(link), 32'h41);
    do_cycle(0, 0, 1, 0, 4'hF, 16'h0, 16'h0200, 0, 5'h0, 16'h0);
    check_value("jal_pc", 32'(pc), 32'h200);

    // Same-cycle flagWrite does not affect the branch decision
    do_cycle(0, 0, 0, 1, 4'h0, 16'h0010, 16'h0, 1, 5'b00000, 16'h0);
    check_value("oldflag_pc", 32'(pc), 32'h210);
    check_value("oldflag_flags", 32'(flags), 32'h0);

    // Branch below zero wraps
    jump_to(16'h0002);
    do_cycle(0, 0, 0, 1, 4'hE, 16'hFFF0, 16'h0, 0, 5'h0, 16'h0);
    check_value("negwrap_pc", 32'(pc), 32'hFFF2);

    // Asynchronous reset during an active branch
    do_cycle(1, 0, 0, 0, 4'h0, 16'h0, 16'h0, 1, 5'b11111, 16'hBEEF);
    fetchPhase = 0; pcBranch = 1; flagOp = 4'hE; immediate = 16'h0100;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_state("midrst");
    #3;
    pcBranch = 0;
    reset = 1'b1;

    // Random command stream
    for (int i = 0; i < 400; i++) begin
      int  kind;
      bit  f, a, j, b, fw;
      logic [15:0] imm, tgt;
      kind = $urandom_range(0, 9);
      a = (kind <= 2) || (kind == 9);
      j = (kind == 3) || (kind == 4);
      b = (kind == 5) || (kind == 6);
      if (kind == 8) begin
        a = 1'($urandom); j = 1'($urandom); b = 1'($urandom);
      end
      f  = ($urandom_range(0, 3) == 0);
      fw = ($urandom_range(0, 2) == 0);
      imm = ($urandom_range(0, 1) == 0) ? 16'($signed(5'($urandom))) : 16'($urandom);
      case ($urandom_range(0, 3))
        0: tgt = 16'hFFFF;
        1: tgt = 16'h0000;
        default: tgt = 16'($urandom);
      endcase
      if ($urandom_range(0, 99) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_state("rndrst");
        #2;
        reset = 1'b1;
      end
      do_cycle(f, a, j, b, 4'($urandom), imm, tgt, fw, 5'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
